// File: rtl/param_calc_pkg.sv
// Shared definitions for the EEG window feature calculator (mean / std per sign class).
package param_calc_pkg;
  localparam int SIGN_BIT  = 17;
  localparam int INT_BITS  = 5;
  localparam int FRAC_BITS = 12;
  localparam int MAG_W     = INT_BITS + FRAC_BITS;
  localparam int MEAN_W    = 18;
  localparam int STD_W     = 19;
  // squared deviation kept at FRAC_BITS fraction bits
  localparam int SQ_W      = 2*MAG_W - FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_MEAN_RD, S_MEAN_DIV, S_STD_RD, S_VAR_DIV, S_SQRT, S_DONE
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sample_t;
endpackage

// File: rtl/param_calc_sqrt.sv
// Iterative restoring integer square root, one result bit per cycle; root and remainder
// are valid while done pulses.
module param_calc_sqrt #(
  parameter int W = 34
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   radicand,
  output logic [W/2-1:0] root,
  output logic [W/2+1:0] rem,
  output logic           done
);
  localparam int RW = W/2;
  localparam int CW = $clog2(RW+1);

  logic [W-1:0]    rad_q, rad_d;
  logic [RW-1:0]   root_q, root_d;
  logic [RW+1:0]   rem_q, rem_d, acc, trial;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;

  always_comb begin
    rad_d  = rad_q;
    root_d = root_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    acc    = (rem_q << 2) | (RW+2)'(rad_q[W-1:W-2]);
    trial  = {root_q, 2'b01};
    if (start) begin
      rad_d  = radicand;
      root_d = '0;
      rem_d  = '0;
      cnt_d  = CW'(RW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = rad_q << 2;
      if (acc >= trial) begin
        rem_d  = acc - trial;
        root_d = (root_q << 1) | RW'(1);
      end else begin
        rem_d  = acc;
        root_d = root_q << 1;
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      root_q <= root_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign root = root_q;
  assign rem  = rem_q;
  assign done = done_q;
endmodule

// File: rtl/param_calc.sv
// Two-pass window reducer: pass 1 means, pass 2 population std, per sign class.
// Define PARAM_CALC_ROUND_EN to round divides and sqrt to nearest instead of truncating.
module param_calc
  import param_calc_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 8,
  parameter int N_SAMPLES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pc_fifo_data,
  output logic [ADDR_WIDTH-1:0] pc_fifo_addr,
  output logic                  pc_fifo_read,
  output logic [MEAN_W-1:0]     mean_pos,
  output logic [STD_W-1:0]      std_pos,
  output logic [MEAN_W-1:0]     mean_neg,
  output logic [STD_W-1:0]      std_neg,
  output logic                  param_calc_finish
);
`ifdef PARAM_CALC_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif
  localparam int LOG_N   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int SUM_W   = MAG_W + LOG_N;
  localparam int SQS_W   = SQ_W + LOG_N;
  localparam int CNT_W   = $clog2(N_SAMPLES + 1);
  localparam int NUM_W   = SQS_W + 1;
  // quotient bit counts rounded up to even: the divider retires two bits per cycle
  localparam int QB_MEAN = MAG_W + (MAG_W % 2);
  localparam int QB_VAR  = SQ_W + (SQ_W % 2);
  localparam int QMAX    = QB_VAR;
  localparam int RT_W    = SQ_W + FRAC_BITS;
  localparam int RR_W    = RT_W/2;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       rd_q, rd_d;
  logic [1:0][SUM_W-1:0]      sum_q, sum_d;
  logic [1:0][SQS_W-1:0]      sqs_q, sqs_d;
  logic [1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0][MAG_W-1:0]      mean_r_q, mean_r_d;
  logic [1:0][SQ_W-1:0]       var_q, var_d;
  logic                       dcls_q, dcls_d;
  logic [4:0]                 dcyc_q, dcyc_d;
  logic [CNT_W-1:0]           drem_q, drem_d;
  logic [QMAX-1:0]            dsh_q, dsh_d, dquo_q, dquo_d;
  logic                       sq_start_q, sq_start_d;
  logic [MEAN_W-1:0]          mean_pos_q, mean_pos_d, mean_neg_q, mean_neg_d;
  logic [STD_W-1:0]           std_pos_q, std_pos_d, std_neg_q, std_neg_d;
  logic                       fin_q, fin_d;

  sample_t                    smp;
  logic [MAG_W-1:0]           diff;
  logic [2*MAG_W-1:0]         sq;
  logic [SQ_W-1:0]            term;
  logic                       is_var, last;
  logic [NUM_W-1:0]           dnum;
  logic [CNT_W-1:0]           dden, r, rem_ld;
  logic [CNT_W:0]             t;
  logic [QMAX-1:0]            sh, q, sh_ld;
  logic [4:0]                 dsteps;

  logic [1:0][RT_W-1:0]       sq_rad;
  logic [1:0][RR_W-1:0]       sq_root;
  logic [1:0][RR_W+1:0]       sq_rem;
  logic [1:0]                 sq_done, sq_bump;

  for (genvar g = 0; g < 2; g++) begin : g_sqrt
    assign sq_rad[g]  = {var_q[g], {FRAC_BITS{1'b0}}};
    assign sq_bump[g] = ROUND_EN && (sq_rem[g] > (RR_W+2)'(sq_root[g]));
    param_calc_sqrt #(.W(RT_W)) u_sqrt (
      .clk      (clk),
      .reset    (reset),
      .start    (sq_start_q),
      .radicand (sq_rad[g]),
      .root     (sq_root[g]),
      .rem      (sq_rem[g]),
      .done     (sq_done[g])
    );
  end

  // sample decode and squared deviation for the STD pass
  always_comb begin
    smp  = pc_fifo_data[SIGN_BIT:0];
    diff = (smp.mag >= mean_r_q[smp.sign]) ? smp.mag - mean_r_q[smp.sign]
                                           : mean_r_q[smp.sign] - smp.mag;
    sq   = diff * diff;
    term = SQ_W'(sq >> FRAC_BITS);
    last = (addr_q == ADDR_WIDTH'(N_SAMPLES - 1));
  end

  // shared divider datapath: load values and a two-bit restoring step
  always_comb begin
    is_var = (state_q == S_VAR_DIV);
    dsteps = is_var ? 5'(QB_VAR/2) : 5'(QB_MEAN/2);
    dden   = cnt_q[dcls_q];
    dnum   = is_var ? NUM_W'(sqs_q[dcls_q]) : NUM_W'(sum_q[dcls_q]);
    if (ROUND_EN) dnum = dnum + NUM_W'(dden >> 1);
    // quotient fits QB bits, so the bits above QB are already a valid partial remainder
    rem_ld = is_var ? CNT_W'(dnum >> QB_VAR) : CNT_W'(dnum >> QB_MEAN);
    sh_ld  = is_var ? QMAX'(dnum) : QMAX'(dnum << (QMAX - QB_MEAN));
    r = drem_q;
    sh = dsh_q;
    q = dquo_q;
    t = '0;
    for (int k = 0; k < 2; k++) begin
      t  = {r, sh[QMAX-1]};
      sh = sh << 1;
      if (t >= {1'b0, dden}) begin
        t = t - {1'b0, dden};
        q = (q << 1) | QMAX'(1);
      end else begin
        q = q << 1;
      end
      r = t[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    sum_d      = sum_q;
    sqs_d      = sqs_q;
    cnt_d      = cnt_q;
    mean_r_d   = mean_r_q;
    var_d      = var_q;
    dcls_d     = dcls_q;
    dcyc_d     = dcyc_q;
    drem_d     = drem_q;
    dsh_d      = dsh_q;
    dquo_d     = dquo_q;
    sq_start_d = 1'b0;
    mean_pos_d = mean_pos_q;
    mean_neg_d = mean_neg_q;
    std_pos_d  = std_pos_q;
    std_neg_d  = std_neg_q;
    fin_d      = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_MEAN_RD;
        rd_d    = 1'b1;
        addr_d  = '0;
        sum_d   = '0;
        sqs_d   = '0;
        cnt_d   = '0;
      end
      S_MEAN_RD, S_STD_RD: if (!rd_q) begin
        if (state_q == S_MEAN_RD) begin
          sum_d[smp.sign] = sum_q[smp.sign] + SUM_W'(smp.mag);
          cnt_d[smp.sign] = cnt_q[smp.sign] + 1'b1;
        end else begin
          sqs_d[smp.sign] = sqs_q[smp.sign] + SQS_W'(term);
        end
        if (last) begin
          state_d = (state_q == S_MEAN_RD) ? S_MEAN_DIV : S_VAR_DIV;
          dcls_d  = 1'b0;
          dcyc_d  = '0;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      S_MEAN_DIV, S_VAR_DIV: begin
        if (dcyc_q == '0) begin
          drem_d = rem_ld;
          dsh_d  = sh_ld;
          dquo_d = '0;
          dcyc_d = 5'd1;
        end else begin
          drem_d = r;
          dsh_d  = sh;
          dquo_d = q;
          dcyc_d = dcyc_q + 1'b1;
          if (dcyc_q == dsteps) begin
            dcyc_d = '0;
            dcls_d = ~dcls_q;
            // empty class: result is defined as zero
            if (is_var) var_d[dcls_q]    = (dden == '0) ? '0 : SQ_W'(q);
            else        mean_r_d[dcls_q] = (dden == '0) ? '0 : MAG_W'(q);
            if (dcls_q) begin
              if (is_var) begin
                state_d    = S_SQRT;
                sq_start_d = 1'b1;
              end else begin
                state_d = S_STD_RD;
                rd_d    = 1'b1;
                addr_d  = '0;
              end
            end
          end
        end
      end
      S_SQRT: if (sq_done[0]) begin
        state_d    = S_DONE;
        fin_d      = 1'b1;
        mean_pos_d = MEAN_W'(mean_r_q[0]);
        mean_neg_d = MEAN_W'(mean_r_q[1]);
        std_pos_d  = STD_W'(sq_root[0]) + STD_W'(sq_bump[0]);
        std_neg_d  = STD_W'(sq_root[1]) + STD_W'(sq_bump[1]);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      sum_q      <= '0;
      sqs_q      <= '0;
      cnt_q      <= '0;
      mean_r_q   <= '0;
      var_q      <= '0;
      dcls_q     <= 1'b0;
      dcyc_q     <= '0;
      drem_q     <= '0;
      dsh_q      <= '0;
      dquo_q     <= '0;
      sq_start_q <= 1'b0;
      mean_pos_q <= '0;
      mean_neg_q <= '0;
      std_pos_q  <= '0;
      std_neg_q  <= '0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      sum_q      <= sum_d;
      sqs_q      <= sqs_d;
      cnt_q      <= cnt_d;
      mean_r_q   <= mean_r_d;
      var_q      <= var_d;
      dcls_q     <= dcls_d;
      dcyc_q     <= dcyc_d;
      drem_q     <= drem_d;
      dsh_q      <= dsh_d;
      dquo_q     <= dquo_d;
      sq_start_q <= sq_start_d;
      mean_pos_q <= mean_pos_d;
      mean_neg_q <= mean_neg_d;
      std_pos_q  <= std_pos_d;
      std_neg_q  <= std_neg_d;
      fin_q      <= fin_d;
    end
  end

  assign pc_fifo_addr      = addr_q;
  assign pc_fifo_read      = rd_q;
  assign mean_pos          = mean_pos_q;
  assign mean_neg          = mean_neg_q;
  assign std_pos           = std_pos_q;
  assign std_neg           = std_neg_q;
  assign param_calc_finish = fin_q;
endmodule

// File: tb/tb_param_calc.sv
// Directed bench for param_calc: FIFO model, read monitor and a result scoreboard.
module tb_param_calc;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [17:0] pc_fifo_data;
  logic [7:0]  pc_fifo_addr;
  logic        pc_fifo_read;
  logic [17:0] mean_pos, mean_neg;
  logic [18:0] std_pos, std_neg;
  logic        param_calc_finish;

  always #5 clk = ~clk;

  param_calc #(.DATA_WIDTH(18), .ADDR_WIDTH(8), .N_SAMPLES(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .pc_fifo_data(pc_fifo_data), .pc_fifo_addr(pc_fifo_addr), .pc_fifo_read(pc_fifo_read),
    .mean_pos(mean_pos), .std_pos(std_pos), .mean_neg(mean_neg), .std_neg(std_neg),
    .param_calc_finish(param_calc_finish)
  );

  typedef struct { logic [17:0] mp, mn; logic [18:0] sp, sn; } exp_t;
  exp_t        sb[$];
  int          nvec = 0, nerr = 0;
  logic [17:0] mem [256];
  int          rd_cnt = 0, fin_cnt = 0, b2b = 0;
  logic [7:0]  addr_log[$];
  logic        rd_l = 1'b0, rd_prev = 1'b0;
  logic [7:0]  a_l = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint n, input longint d);
`ifdef PARAM_CALC_ROUND_EN
    return (2*n + d) / (2*d);
`else
    return n / d;
`endif
  endfunction

  function automatic longint isqrt(input longint x);
    longint lo = 0, hi = 64'd1 << 20, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid*mid <= x) lo = mid; else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint fsqrt(input longint x);
`ifdef PARAM_CALC_ROUND_EN
    return (isqrt(4*x) + 1) / 2;
`else
    return isqrt(x);
`endif
  endfunction

  function automatic exp_t model();
    longint sum[2], cnt[2], sqs[2], mn[2], sd[2], d;
    exp_t e;
    for (int c = 0; c < 2; c++) begin sum[c] = 0; cnt[c] = 0; sqs[c] = 0; end
    for (int i = 0; i < N; i++) begin
      sum[mem[i][17]] += longint'(mem[i][16:0]);
      cnt[mem[i][17]] += 1;
    end
    for (int c = 0; c < 2; c++) mn[c] = (cnt[c] == 0) ? 0 : fdiv(sum[c], cnt[c]);
    for (int i = 0; i < N; i++) begin
      d = longint'(mem[i][16:0]) - mn[mem[i][17]];
      sqs[mem[i][17]] += (d*d) >>> 12;
    end
    for (int c = 0; c < 2; c++)
      sd[c] = (cnt[c] == 0) ? 0 : fsqrt(fdiv(sqs[c], cnt[c]) << 12);
    e.mp = 18'(mn[0]); e.mn = 18'(mn[1]); e.sp = 19'(sd[0]); e.sn = 19'(sd[1]);
    return e;
  endfunction

  // FIFO: data is valid only in the cycle after a strobe, garbage otherwise
  always @(posedge clk) begin
    #1;
    pc_fifo_data = rd_l ? mem[a_l] : 18'h2AAAA;
  end

  always @(negedge clk) begin
    exp_t e;
    rd_l = pc_fifo_read;
    a_l  = pc_fifo_addr;
    if (pc_fifo_read) begin
      rd_cnt++;
      addr_log.push_back(pc_fifo_addr);
      if (rd_prev) b2b++;
    end
    rd_prev = pc_fifo_read;
    if (param_calc_finish) begin
      fin_cnt++;
      chk("unexpected_finish", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mean_pos", mean_pos, e.mp);
        chk("mean_neg", mean_neg, e.mn);
        chk("std_pos", std_pos, e.sp);
        chk("std_neg", std_neg, e.sn);
      end
    end
  end

  task automatic clear_mon();
    rd_cnt = 0; fin_cnt = 0; b2b = 0; addr_log.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fin();
    for (int k = 0; k < 4*N + 100 && fin_cnt == 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("finish_pulses", fin_cnt, 1);
    sb.delete();
  endtask

  task automatic run_window();
    clear_mon();
    sb.push_back(model());
    pulse_start();
    wait_fin();
  endtask

  task automatic load_spec_window();
    logic [17:0] w [16];
    w = '{18'h00800, 18'h22000, 18'h00400, 18'h28800, 18'h00800, 18'h22000, 18'h00400, 18'h28800,
          18'h03800, 18'h22C00, 18'h10400, 18'h28C00, 18'h00200, 18'h22000, 18'h01400, 18'h28800};
    for (int i = 0; i < N; i++) mem[i] = w[i];
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) mem[i] = 18'($urandom);
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; pc_fifo_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #12;
    chk("rst_mean_pos", mean_pos, 0);
    chk("rst_std_neg", std_neg, 0);
    chk("rst_read", pc_fifo_read, 0);
    chk("rst_addr", pc_fifo_addr, 0);
    chk("rst_finish", param_calc_finish, 0);
    @(negedge clk) reset = 1'b0;

    // reference window from the test plan
    load_spec_window();
    run_window();
    chk("spec_mean_pos", mean_pos, 18'h02D40);
    chk("spec_mean_neg", mean_neg, 18'h05600);
    chk("spec_std_pos_tol", 64'(std_pos >= 19'd21209 && std_pos <= 19'd21213), 1);
    chk("spec_std_neg_tol", 64'(std_neg >= 19'd13091 && std_neg <= 19'd13095), 1);
    chk("rd_strobes", rd_cnt, 2*N);
    chk("rd_back_to_back", b2b, 0);
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++) if (addr_log[k] != 8'(k % N)) bad++;
    chk("rd_addr_seq", bad, 0);

    // only positive samples: negative class empty
    for (int i = 0; i < N; i++) mem[i] = 18'h01000;
    run_window();
    chk("allpos_mean_pos", mean_pos, 18'h01000);
    chk("allpos_std_pos", std_pos, 0);
    chk("allpos_mean_neg", mean_neg, 0);

    // -0 counts as negative
    for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0) ? 18'h20000 : 18'h05000;
    run_window();

    load_random();
    run_window();

    // reset during the second pass
    load_spec_window();
    clear_mon();
    pulse_start();
    for (int k = 0; k < 4*N + 100 && rd_cnt < N + 3; k++) @(negedge clk);
    chk("reached_std_rd", 64'(rd_cnt >= N + 3), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_read", pc_fifo_read, 0);
    chk("midrst_mean_pos", mean_pos, 0);
    chk("midrst_std_pos", std_pos, 0);
    chk("midrst_finish", param_calc_finish, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_no_finish", fin_cnt, 0);
    load_random();
    run_window();

    // second start mid-window and a start during DONE are both ignored
    load_random();
    clear_mon();
    sb.push_back(model());
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    for (int k = 0; k < 4*N + 100 && !param_calc_finish; k++) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4*N + 100) @(negedge clk);
    chk("dbl_start_finish", fin_cnt, 1);
    chk("dbl_start_strobes", rd_cnt, 2*N);
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/param_calc.md
Name: param_calc

Overview:
- Computes per-window EEG feature parameters: mean and standard deviation of sample magnitudes, with positive and negative samples reduced separately.
- Reads one window of N sign-magnitude samples from the preceding sample FIFO/RAM twice, through an address/read-strobe port.
- Pass 1 produces the means; pass 2 produces the population standard deviations.
- Results feed the downstream classifier, qualified by a one-cycle finish pulse.

Parameters:
- DATA_WIDTH, 18, sample width; format is [17] sign, [16:12] integer, [11:0] fraction (sign-magnitude Q5.12).
- ADDR_WIDTH, 8, FIFO address width.
- N_SAMPLES, 16, samples per window; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to process one window.
- pc_fifo_data  in  DATA_WIDTH  sample returned by the FIFO.
- pc_fifo_addr  out  ADDR_WIDTH  sample address.
- pc_fifo_read  out  1  read strobe.
- mean_pos  out  18  mean magnitude of positive samples, Q5.12; bit 17 is always 0.
- std_pos  out  19  standard deviation of positive samples, unsigned Q7.12.
- mean_neg  out  18  mean magnitude of negative samples, Q5.12 magnitude; bit 17 is always 0.
- std_neg  out  19  standard deviation of negative samples, unsigned Q7.12.
- param_calc_finish  out  1  one-cycle done pulse.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Accumulators and counters are cleared.
  - Reset mid-operation abandons the window; no finish pulse is produced.
- Read protocol:
  - In cycle t the block drives pc_fifo_read=1 with pc_fifo_addr=a.
  - pc_fifo_data is valid and sampled at the edge ending cycle t+1.
  - Reads are issued every other cycle for addresses 0..N_SAMPLES-1.
  - pc_fifo_read is 0 outside the read states.
  - pc_fifo_addr holds its last value when idle and resets to 0.
- Classification:
  - Sign bit 0 → positive class; sign bit 1 → negative class. This includes -0.
  - Magnitude is bits [16:0].
- FSM states:
  - IDLE: start=1 → MEAN_RD.
  - MEAN_RD: accumulate magnitude sum and count per class. Sums are 17+log2(N) bits, exact.
  - MEAN_DIV: mean = sum / count using a sequential restoring divider, truncated to Q5.12.
  - STD_RD: re-read the same N addresses. For each sample, accumulate (|x| − mean_class)², squared term truncated to 12 fraction bits.
  - VAR_DIV: variance = sqsum / count per class.
  - SQRT: std = integer sqrt of (variance << 12), giving Q7.12, truncated.
  - DONE: outputs register, param_calc_finish=1 for exactly one cycle, then IDLE.
- Counts and edge cases:
  - count=0 for a class → that class's mean and std are 0; no divide is performed.
  - start while not IDLE is ignored.
  - start asserted in DONE is ignored; it is accepted again in IDLE.
- Output timing:
  - Outputs update only in DONE and hold until the next DONE or reset.
- Total latency from start to finish is fixed for a given N_SAMPLES: ≤ 4·N_SAMPLES + 100 cycles, independent of data.

Optional Feature:
- PARAM_CALC_ROUND_EN defined: every divide and the sqrt round to nearest (half up) at the 12-fraction-bit LSB.
- Undefined: all results truncate toward zero.
- Port list and latency are identical in both builds.

Decomposition:
- Shared package param_calc_pkg:
  - sample field positions (SIGN_BIT=17, INT_BITS=5, FRAC_BITS=12);
  - output widths (MEAN_W=18, STD_W=19);
  - FSM state enum;
  - sample typedef.
- One sub-module is natural: param_calc_sqrt, an iterative restoring integer square root with start/done handshake.
- Division is a shared sequential restoring divider inside param_calc, time-multiplexed over the pos and neg classes.

Test Plan:
- Window 0x00800,0x22000,0x00400,0x28800, the same 4 again, then 0x03800,0x22C00,0x10400,0x28C00,0x00200,0x22000,0x01400,0x28800, for both passes:
  - mean_pos=0x02D40 (2.828125);
  - mean_neg=0x05600 (5.375);
  - std_pos=21211 ±2 LSB (5.1784);
  - std_neg=13093 ±2 LSB (3.1967);
  - one finish pulse.
- All 16 samples 0x01000 (+1.0) → mean_pos=0x01000, std_pos=0, mean_neg=0, std_neg=0. Exercises the count=0 path.
- Read sequencing check:
  - exactly 2·N_SAMPLES read strobes;
  - addresses 0..15 twice;
  - data sampled one cycle after each strobe.
- Reset asserted mid-STD_RD:
  - outputs and read strobe go to 0 immediately, with no finish pulse;
  - a new start then gives correct results.
- A second start pulse during processing is ignored: single finish pulse, results unchanged.
- Build with PARAM_CALC_ROUND_EN defined: same vectors; std results differ from truncation by ≤1 LSB and are round-to-nearest correct.
